// File: rtl/rvx_bus_copier.sv
// Block copier that masters the RVX IO request/response bus, moving whole
// 32-bit words from a source range to a destination range with a response timeout.
module rvx_bus_copier #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int COUNT_WIDTH    = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [31:0]            src_address,
    input  logic [31:0]            dst_address,
    input  logic [COUNT_WIDTH-1:0] word_count,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [COUNT_WIDTH-1:0] words_done,
    output logic [31:0]            rw_address,
    input  logic [31:0]            read_data,
    output logic                   read_request,
    input  logic                   read_response,
    output logic [31:0]            write_data,
    output logic [3:0]             write_strobe,
    output logic                   write_request,
    input  logic                   write_response
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        WR_REQ  = 3'd3,
        WR_WAIT = 3'd4,
        FINISH  = 3'd5
    } state_t;

    state_t                 state;
    state_t                 state_nx;
    logic [31:0]            src_cur;
    logic [31:0]            dst_cur;
    logic [COUNT_WIDTH-1:0] count_lat;
    logic [15:0]            tmo_cnt;
    logic                   misaligned;
    logic                   last_word;
    logic                   tmo_hit;

    assign misaligned = (src_address[1:0] != 2'b00) || (dst_address[1:0] != 2'b00);
    assign last_word  = (words_done + COUNT_WIDTH'(1)) == count_lat;
    // A response in the final wait cycle is checked first, so it beats the timeout.
    assign tmo_hit    = tmo_cnt == 16'(TIMEOUT_CYCLES - 1);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start) begin
                    if (misaligned || (word_count == '0)) begin
                        state_nx = FINISH;
                    end else begin
                        state_nx = RD_REQ;
                    end
                end
            end
            RD_REQ:  state_nx = RD_WAIT;
            RD_WAIT: begin
                if (read_response) begin
                    state_nx = WR_REQ;
                end else if (tmo_hit) begin
                    state_nx = FINISH;
                end
            end
            WR_REQ:  state_nx = WR_WAIT;
            WR_WAIT: begin
                if (write_response) begin
                    state_nx = last_word ? FINISH : RD_REQ;
                end else if (tmo_hit) begin
                    state_nx = FINISH;
                end
            end
            FINISH:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy          = 1'b0;
        done          = 1'b0;
        rw_address    = 32'h0;
        read_request  = 1'b0;
        write_request = 1'b0;
        write_strobe  = 4'b0000;
        case (state)
            RD_REQ: begin
                busy         = 1'b1;
                read_request = 1'b1;
                rw_address   = src_cur;
            end
            RD_WAIT: begin
                busy       = 1'b1;
                rw_address = src_cur;
            end
            WR_REQ: begin
                busy          = 1'b1;
                write_request = 1'b1;
                write_strobe  = 4'b1111;
                rw_address    = dst_cur;
            end
            WR_WAIT: begin
                busy         = 1'b1;
                write_strobe = 4'b1111;
                rw_address   = dst_cur;
            end
            FINISH:  done = 1'b1;
            default: ;
        endcase
    end

    // Address and length registers carry no reset; they are only observed outside IDLE.
    always_ff @(posedge clock) begin
        case (state)
            IDLE: begin
                if (start) begin
                    src_cur   <= src_address;
                    dst_cur   <= dst_address;
                    count_lat <= word_count;
                end
            end
            WR_WAIT: begin
                if (write_response) begin
                    src_cur <= src_cur + 32'd4;
                    dst_cur <= dst_cur + 32'd4;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            error      <= 1'b0;
            words_done <= '0;
            write_data <= 32'h0;
            tmo_cnt    <= 16'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        error      <= misaligned;
                        words_done <= '0;
                    end
                end
                RD_REQ: tmo_cnt <= 16'h0;
                RD_WAIT: begin
                    if (read_response) begin
                        write_data <= read_data;
                    end else if (tmo_hit) begin
                        error <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
                WR_REQ: tmo_cnt <= 16'h0;
                WR_WAIT: begin
                    if (write_response) begin
                        words_done <= words_done + COUNT_WIDTH'(1);
                    end else if (tmo_hit) begin
                        error <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
